// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: Philips I2S transmit serializer, bus master.
// Takes samples through a one-deep holding buffer (valid/ready), derives sck
// from pclk with a programmable divider and shifts MSB-first on falling sck.
// Optional build macro I2S_TX_MONO_EN: controls[1]=1 repeats each sample in
// both slots (default build: controls[1] ignored, stereo).
module i2s_tx_serializer #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [31:0]       controls,
    output logic              sck,
    output logic              ws,
    output logic              sd,
    output logic              underrun,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_PRE  = BW'(DATA_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic              sck_q;
    logic              ws_q;        // also the channel pointer: 0=left, 1=right
    logic              sd_q;
    logic              underrun_q;
    logic              lead_half_q; // LEAD: first falling edge already seen
    logic [BW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;

    logic              enable;
    logic [DIV_W-1:0]  div;
    logic              cnt_wrap;
    logic              fall_evt;
    logic              xfer;
    logic              is_load;
    logic              reuse_d;
    logic              consume_d;
    logic              underrun_d;
    logic [DATA_W-1:0] fresh_word_d;
    logic [DATA_W-1:0] load_word_d;
    logic              unused_ctrl;

    assign enable   = controls[0];
    assign div      = controls[8 +: DIV_W];
    // Remaining control bits are reserved for other blocks.
    assign unused_ctrl = ^{controls[31:8+DIV_W], controls[7:1]};

    // Divider compare uses >= so a div decrease mid-count cannot stall sck.
    assign cnt_wrap = (cnt_q >= div);
    assign fall_evt = (state_q != ST_IDLE) & sck_q & cnt_wrap;

    // Ready is gated by reset so it is low immediately while preset is held.
    assign tx_ready = preset & enable & ~hold_full_q;
    assign xfer     = tx_valid & tx_ready;

    assign is_load = fall_evt & (((state_q == ST_LEAD) & lead_half_q) |
                                 ((state_q == ST_RUN) & (bit_cnt_q == BIT_LAST)));

    assign fresh_word_d = hold_full_q ? hold_q : '0;

`ifdef I2S_TX_MONO_EN
    logic [DATA_W-1:0] mono_q;

    // Right slot in mono mode replays the word captured at the left load.
    assign reuse_d     = controls[1] & ws_q;
    assign load_word_d = reuse_d ? mono_q : fresh_word_d;

    // Capture the left-slot word for replay in the right slot.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            mono_q <= '0;
        end else if (is_load && !reuse_d) begin
            mono_q <= fresh_word_d;
        end
    end
`else
    assign reuse_d     = 1'b0;
    assign load_word_d = fresh_word_d;
`endif

    assign consume_d  = is_load & ~reuse_d;
    assign underrun_d = consume_d & ~hold_full_q;

    // Sequencer: holding buffer, divider, bit counter and registered I2S outputs.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b1;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
            lead_half_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (!enable) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b1;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
            lead_half_q <= 1'b0;
            bit_cnt_q   <= '0;
            hold_full_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;

            // A load and a new transfer in the same cycle keep the buffer full.
            if (xfer) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end else if (consume_d) begin
                hold_full_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q       <= '0;
                    sck_q       <= 1'b0;
                    ws_q        <= 1'b1;
                    sd_q        <= 1'b0;
                    lead_half_q <= 1'b0;
                    bit_cnt_q   <= '0;
                    if (hold_full_q) begin
                        state_q <= ST_LEAD;
                    end
                end
                default: begin
                    if (cnt_wrap) begin
                        cnt_q <= '0;
                        sck_q <= ~sck_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end

                    if (fall_evt) begin
                        if (state_q == ST_LEAD && !lead_half_q) begin
                            ws_q        <= 1'b0;
                            sd_q        <= 1'b0;
                            lead_half_q <= 1'b1;
                        end else if (is_load) begin
                            state_q   <= ST_RUN;
                            shift_q   <= load_word_d << 1;
                            sd_q      <= load_word_d[DATA_W-1];
                            bit_cnt_q <= '0;
                        end else begin
                            shift_q   <= shift_q << 1;
                            sd_q      <= shift_q[DATA_W-1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_PRE) begin
                                ws_q <= ~ws_q;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign sck      = sck_q;
    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: drives i2s_tx_serializer with directed and random
// sample streams and decodes sck/ws/sd with an independent I2S receiver.
module tb_i2s_tx_serializer;

    localparam int DATA_W = 32;
    localparam int DIV_W  = 8;

    logic              pclk = 1'b0;
    logic              preset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [31:0]       controls;
    logic              sck, ws, sd, underrun, busy;

    int n_assert = 0;
    int n_fail   = 0;

    i2s_tx_serializer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .pclk     (pclk),
        .preset   (preset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .controls (controls),
        .sck      (sck),
        .ws       (ws),
        .sd       (sd),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 pclk = ~pclk;

    // Receiver / monitor state
    logic [DATA_W-1:0] rx_q[$];
    int                rx_ch_q[$];
    int                rx_hs_q[$];
    logic [DATA_W-1:0] rx_sr;
    int                rx_cnt;
    logic              rx_ws;
    int                rx_ch;
    bit                rx_started, rx_active;
    logic              sck_prev = 1'b0;
    logic              ur_prev = 1'b0;
    int                hs_cnt, ur_cyc, ur_pulses;
    int                cyc = 0, last_rise = 0, period = 0;

    // Standard I2S receiver: sample on rising sck; a ws change marks the LSB
    // of the word in progress, and the next bit is the MSB of the new slot.
    always @(negedge pclk) begin
        cyc++;
        if (tx_valid && tx_ready) hs_cnt++;
        if (underrun) begin
            ur_cyc++;
            if (!ur_prev) ur_pulses++;
        end
        ur_prev = underrun;
        if (sck && !sck_prev) begin
            if (last_rise != 0) period = cyc - last_rise;
            last_rise = cyc;
            rx_sr = {rx_sr[DATA_W-2:0], sd};
            rx_cnt++;
            if (rx_started && ws !== rx_ws) begin
                if (rx_active) begin
                    rx_q.push_back(rx_sr);
                    rx_ch_q.push_back(rx_ch);
                    rx_hs_q.push_back(hs_cnt);
                end
                rx_active = 1'b1;
                rx_ch     = int'(ws);
                rx_cnt    = 0;
            end
            rx_ws      = ws;
            rx_started = 1'b1;
        end
        sck_prev = sck;
    end

    task automatic rx_clear();
        rx_q.delete();
        rx_ch_q.delete();
        rx_hs_q.delete();
        rx_sr = '0; rx_cnt = 0; rx_ws = 1'b1; rx_ch = 0;
        rx_started = 1'b0; rx_active = 1'b0;
        hs_cnt = 0; ur_cyc = 0; ur_pulses = 0;
        last_rise = 0; period = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl(input bit en, input bit mono, input int div);
        return {16'b0, 8'(div), 6'b0, mono, en};
    endfunction

    task automatic tick();
        @(posedge pclk); #1;
    endtask

    // Offer one sample and hold it until accepted (bounded).
    task automatic push(input logic [DATA_W-1:0] d, input string tag);
        bit acc = 1'b0;
        int c = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!acc && c < 5000) begin
            @(negedge pclk);
            acc = tx_ready;
            tick();
            c++;
        end
        tx_valid = 1'b0;
        check({tag, "_accept"}, 32'(acc), 32'd1);
    endtask

    task automatic wait_words(input int n, input string tag);
        int c = 0;
        while (rx_q.size() < n && c < 20000) begin
            @(negedge pclk); #1;
            c++;
        end
        check({tag, "_words_seen"}, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic disable_idle();
        tx_valid = 1'b0;
        controls = ctl(0, 0, 0);
        repeat (3) tick();
    endtask

    // Continuous valid stream: each handshake presents a fresh random word.
    task automatic stream(input int div, input int n, input string tag);
        logic [DATA_W-1:0] exp_q[$];
        bit acc;
        int c = 0;
        controls = ctl(1, 0, div);
        rx_clear();
        tx_data  = $urandom;
        tx_valid = 1'b1;
        exp_q.push_back(tx_data);
        while (rx_q.size() < n && c < 40000) begin
            @(negedge pclk);
            acc = tx_ready;
            tick();
            if (acc) begin
                tx_data = $urandom;
                exp_q.push_back(tx_data);
            end
            c++;
        end
        tx_valid = 1'b0;
        check({tag, "_words_seen"}, 32'(rx_q.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), rx_q[i], exp_q[i]);
            check($sformatf("%s_ch%0d", tag, i), 32'(rx_ch_q[i]), 32'(i % 2));
            check($sformatf("%s_hs%0d", tag, i), 32'(rx_hs_q[i]), 32'(i + 2));
        end
        check({tag, "_sck_period"}, 32'(period), 32'(2 * (div + 1)));
        check({tag, "_no_underrun"}, 32'(ur_pulses), 32'd0);
        disable_idle();
    endtask

    logic [DATA_W-1:0] w_a, w_b;

    initial begin
        // Reset held with enable asserted: ready must still be low.
        preset   = 1'b0;
        controls = ctl(1, 0, 1);
        tx_valid = 1'b1;
        tx_data  = 32'h1234_5678;
        rx_clear();
        #12;
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_ws", 32'(ws), 32'd1);
        check("rst_sd", 32'(sd), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        tx_valid = 1'b0;
        controls = ctl(0, 0, 0);
        tick();
        preset = 1'b1;
        tick();

        // Basic stereo frame, div=1
        controls = ctl(1, 0, 1);
        rx_clear();
        tick();
        check("idle_ready", 32'(tx_ready), 32'd1);
        push(32'hA5A5_0001, "basic_L");
        push(32'h8000_0003, "basic_R");
        wait_words(2, "basic");
        check("basic_L_word", rx_q[0], 32'hA5A5_0001);
        check("basic_L_ch", 32'(rx_ch_q[0]), 32'd0);
        check("basic_R_word", rx_q[1], 32'h8000_0003);
        check("basic_R_ch", 32'(rx_ch_q[1]), 32'd1);
        check("basic_period", 32'(period), 32'd4);
        check("basic_no_underrun", 32'(ur_pulses), 32'd0);
        check("basic_busy", 32'(busy), 32'd1);

        // Asynchronous reset in the middle of a running frame
        repeat (37) tick();
        #2;
        preset = 1'b0;
        #1;
        check("midrst_sck", 32'(sck), 32'd0);
        check("midrst_ws", 32'(ws), 32'd1);
        check("midrst_sd", 32'(sd), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        controls = ctl(0, 0, 0);
        tick();
        preset = 1'b1;
        tick();

        // Underrun: only a left sample is supplied
        controls = ctl(1, 0, 1);
        rx_clear();
        push(32'hFFFF_FFFF, "ur_L");
        wait_words(2, "ur");
        check("ur_L_word", rx_q[0], 32'hFFFF_FFFF);
        check("ur_R_word", rx_q[1], 32'h0);
        check("ur_pulses", 32'(ur_pulses), 32'd1);
        check("ur_width", 32'(ur_cyc), 32'd1);
        disable_idle();

        // Back-pressure: valid held high, div=0
        stream(0, 6, "bp");

        // Disable mid-word: buffered right sample must be dropped
        controls = ctl(1, 0, 1);
        rx_clear();
        w_a = $urandom;
        w_b = $urandom;
        push(w_a, "dis_L1");
        push(w_b, "dis_R1");
        begin
            int c = 0;
            while (!(rx_active && rx_cnt == 10) && c < 5000) begin
                @(negedge pclk); #1;
                c++;
            end
            check("dis_reach_bit10", 32'(rx_active && rx_cnt == 10), 32'd1);
        end
        controls = ctl(0, 0, 1);
        tick();
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_sck", 32'(sck), 32'd0);
        check("dis_ws", 32'(ws), 32'd1);
        check("dis_sd", 32'(sd), 32'd0);
        check("dis_ready", 32'(tx_ready), 32'd0);
        tick();
        rx_clear();
        controls = ctl(1, 0, 1);
        w_a = $urandom;
        w_b = $urandom;
        push(w_a, "dis_L2");
        push(w_b, "dis_R2");
        wait_words(2, "dis_restart");
        check("dis_restart_L", rx_q[0], w_a);
        check("dis_restart_L_ch", 32'(rx_ch_q[0]), 32'd0);
        check("dis_restart_R", rx_q[1], w_b);
        disable_idle();

        // Mono request (controls[1]=1)
        controls = ctl(1, 1, 0);
        rx_clear();
        w_b = $urandom;
        push(32'h0000_1234, "mono_S1");
        push(w_b, "mono_S2");
`ifdef I2S_TX_MONO_EN
        wait_words(4, "mono");
        check("mono_L1", rx_q[0], 32'h0000_1234);
        check("mono_R1", rx_q[1], 32'h0000_1234);
        check("mono_L2", rx_q[2], w_b);
        check("mono_R2", rx_q[3], w_b);
        check("mono_hs_frame1", 32'(rx_hs_q[1]), 32'd2);
        check("mono_hs_frame2", 32'(rx_hs_q[3]), 32'd2);
        check("mono_no_underrun", 32'(ur_pulses), 32'd0);
`else
        wait_words(2, "mono_off");
        check("mono_off_L", rx_q[0], 32'h0000_1234);
        check("mono_off_R", rx_q[1], w_b);
        check("mono_off_no_underrun", 32'(ur_pulses), 32'd0);
`endif
        disable_idle();

        // Random streams with random divider settings
        for (int r = 0; r < 3; r++) begin
            stream(int'($urandom_range(0, 3)), 4, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Transmit-side I2S serializer directly downstream of the APB register block. It consumes the transmit data word and control word that the register block produces, and shifts samples out as a standard Philips I2S stream: sck, ws and sd. It runs as bus master, deriving sck from pclk with a programmable divider, and uses a one-deep holding buffer with a valid/ready handshake.

Parameters:
DATA_W, 32, bits per channel slot; also the sample width.
DIV_W, 8, width of the sck divider field taken from controls.

Ports:
pclk  in  1  system clock, all logic on the rising edge
preset  in  1  asynchronous, active-low reset
tx_data  in  DATA_W  sample to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  holding buffer can accept a sample
controls  in  32  [0]=enable, [1]=mono (optional feature), [8+DIV_W-1:8]=div
sck  out  1  I2S bit clock
ws  out  1  word select: 0=left, 1=right
sd  out  1  serial data, MSB first
underrun  out  1  one-pclk pulse when a slot starts with no sample available
busy  out  1  state is not IDLE

Behaviour:
- Reset (preset=0, asynchronous): state=IDLE; sck=0, ws=1, sd=0, underrun=0, busy=0; holding buffer empty; channel pointer=left; counters=0.
- tx_ready = enable & ~hold_full. It does not depend on tx_valid. A transfer occurs when tx_valid & tx_ready on a pclk edge; holding buffer becomes full on the next edge.
- Samples are consumed strictly alternating left, right, left, ... starting with left after leaving IDLE.
- Divider: cnt counts 0..div. At cnt==div, cnt returns to 0 and sck toggles. sck period = 2*(div+1) pclk cycles; div=0 gives pclk/2.
- fall_evt is the pclk cycle in which sck goes 1->0. All sd and ws changes happen only on fall_evt, registered, so the receiver samples on rising sck.
- IDLE: sck held 0, divider held 0, ws=1, sd=0. Leave IDLE when enable=1 and hold_full=1; go to LEAD.
- LEAD: the divider runs. On the first fall_evt, ws goes to 0 and sd=0. On the next fall_evt, go to RUN and load the first left sample.
- RUN: bit_cnt runs 0..DATA_W-1 and advances on each fall_evt.
  - Load (the fall_evt where bit_cnt wraps to 0): shift register takes the holding buffer, which becomes empty. sd = new MSB.
  - At bit_cnt==DATA_W-2, ws toggles on that fall_evt, so ws leads the next word's MSB by exactly one sck.
  - On other fall_evts, sd = next bit, shifted left.
- Underrun: if the holding buffer is empty at a load, the shift register takes 0, underrun pulses high for that pclk cycle, the channel pointer still advances, and RUN continues.
- Simultaneous transfer and load in the same cycle: the shift register takes the old holding value, the holding buffer takes the new tx_data, and hold_full stays 1.
- enable=0 in any state: on the next pclk edge, state=IDLE, holding buffer cleared, outputs return to their IDLE values. The in-flight word is abandoned.
- Changing div while RUN is active takes effect at the next cnt wrap. It is not glitch-protected; software changes div only while enable=0.
- busy = (state != IDLE).

Optional Feature:
Macro I2S_TX_MONO_EN.
- Defined: when controls[1]=1, each accepted sample is transmitted in both the left and right slot. The holding buffer is emptied only at the left load; the right load reuses the shift value captured at the left load. Underrun is checked only at the left load.
- Not defined: controls[1] is ignored and behaviour is stereo, as above.

Test Plan:
- Reset: preset=0 mid-frame -> sck=0, ws=1, sd=0, tx_ready=0, busy=0 immediately, without waiting for a clock edge.
- Basic stereo frame: div=1, enable=1, push L=32'hA5A5_0001 then R=32'h8000_0003 -> sck period 4 pclk; after the LEAD slot, sd shows the 32 L bits MSB-first while ws=0, then the R bits with ws=1. ws toggles one sck before R's MSB. No underrun.
- Underrun: push only L=32'hFFFF_FFFF -> the R slot transmits 32 zeros and underrun pulses exactly once, for 1 pclk, at the R load.
- Back-pressure: hold tx_valid=1 continuously with div=0 -> tx_ready deasserts after one accept, then reasserts one pclk after each load. Exactly one handshake per 32 sck.
- Disable mid-word: enable=0 at bit_cnt=10 -> IDLE next cycle, the holding buffer is dropped, and re-enabling restarts with LEAD and the left channel.
- I2S_TX_MONO_EN defined, controls[1]=1: push 16'h..1234 sample 32'h0000_1234 -> identical 32 bits appear in the L and R slots, with one handshake per frame.
